// File: rtl/gpu_pkg.sv
// Shared defaults and fetch-state encoding for the instruction prefetch queue.
package gpu_pkg;
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;
  localparam int FCNT_W      = 16;

  typedef enum logic [1:0] {IDLE, FETCH, FULL} fetch_state_e;
endpackage

// File: rtl/prefetch_queue_if.sv
// Command, memory-read and decoder-side signals of the prefetch queue.
// slave = the queue itself, master = whoever drives commands/memory/decoder.
interface prefetch_queue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               start;
  logic [ADDR_W-1:0]  start_pc;
  logic               stop;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mem_read_valid;
  logic [ADDR_W-1:0]  mem_read_addr;
  logic               mem_read_ready;
  logic [INSTR_W-1:0] mem_read_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [15:0]        fetch_count;

  modport slave (
    input  start, start_pc, stop, redirect, redirect_pc,
    input  mem_read_ready, mem_read_data, instr_ready,
    output mem_read_valid, mem_read_addr, instr_valid, instr, instr_pc, fetch_count
  );
  modport master (
    output start, start_pc, stop, redirect, redirect_pc,
    output mem_read_ready, mem_read_data, instr_ready,
    input  mem_read_valid, mem_read_addr, instr_valid, instr, instr_pc, fetch_count
  );
endinterface

// File: rtl/prefetch_queue_fifo.sv
// pq_fifo: circular entry store with flush; storage itself is not reset.
module pq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_push = push && !flush && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop  && !flush && (cnt_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;
endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetch FSM, pc and memory request logic around pq_fifo.
// Define PREFETCH_STATS_EN to build the saturating delivered-instruction counter.
module prefetch_queue
  import gpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input logic              clk,
  input logic              reset,
  prefetch_queue_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     count, cnt_nxt;
  logic [EW-1:0]     head;
  logic              hs, push, pop, flush;

  assign bus.mem_read_valid = (state_q == FETCH) && (count < CW'(DEPTH));
  assign bus.mem_read_addr  = pc_q;
  assign bus.instr_valid    = (count != '0);
  // Storage is unreset, so mask the head while empty.
  assign bus.instr          = bus.instr_valid ? head[EW-1 -: INSTR_W] : '0;
  assign bus.instr_pc       = bus.instr_valid ? head[ADDR_W-1:0] : '0;

  assign hs    = bus.mem_read_valid && bus.mem_read_ready;
  assign flush = bus.stop || bus.redirect;
  assign push  = hs && !flush;
  assign pop   = bus.instr_valid && bus.instr_ready;

  pq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({bus.mem_read_data, pc_q}),
    .rdata (head),
    .count (count)
  );

  // FULL tracks the post-update occupancy so a pop reopens requests next cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.redirect) begin
      state_d = FETCH;
      pc_d    = bus.redirect_pc;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = FETCH;
        pc_d    = bus.start_pc;
      end
    end else begin
      if (push) pc_d = pc_q + ADDR_W'(1);
      state_d = (cnt_nxt == CW'(DEPTH)) ? FULL : FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              start_acc;

  assign start_acc = (state_q == IDLE) && bus.start && !flush;

  always_comb begin
    fcnt_d = fcnt_q;
    if (start_acc)
      fcnt_d = '0;
    else if (pop && !bus.redirect && (fcnt_q != '1))
      fcnt_d = fcnt_q + FCNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

  assign bus.fetch_count = fcnt_q;
`else
  assign bus.fetch_count = '0;
`endif
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed vector table, hand sequences, then
// randomized traffic against a queue-based reference model.
module tb_prefetch_queue;
  localparam int DEPTH = 4;
`ifdef PREFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  prefetch_queue_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(8), .INSTR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'hA5;
  endfunction

  assign bus.mem_read_data = memf(bus.mem_read_addr);

  typedef struct {
    logic       st;  logic [7:0] spc;
    logic       sp;  logic       rd;  logic [7:0] rpc;
    logic       mr;  logic       ir;
    logic       e_mv; logic [7:0] e_ma;
    logic       e_iv; logic [7:0] e_ipc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] spc, input logic sp, input logic rd,
                       input logic [7:0] rpc, input logic mr, input logic ir);
    bus.start = st; bus.start_pc = spc; bus.stop = sp; bus.redirect = rd;
    bus.redirect_pc = rpc; bus.mem_read_ready = mr; bus.instr_ready = ir;
  endtask

  // Reference model: running flag, pc, queue of fetched pcs, delivered count.
  bit          m_run;
  logic [7:0]  m_pc;
  logic [7:0]  m_q[$];
  logic [15:0] m_fc;

  task automatic m_check();
    check("mem_read_valid", bus.mem_read_valid, m_run && (m_q.size() < DEPTH));
    check("mem_read_addr", bus.mem_read_addr, m_pc);
    check("instr_valid", bus.instr_valid, m_q.size() != 0);
    check("instr", bus.instr, (m_q.size() != 0) ? memf(m_q[0]) : 8'h00);
    check("instr_pc", bus.instr_pc, (m_q.size() != 0) ? m_q[0] : 8'h00);
    check("fetch_count", bus.fetch_count, STATS ? m_fc : 16'h0);
  endtask

  task automatic m_step();
    bit hs, pp;
    hs = m_run && (m_q.size() < DEPTH) && bus.mem_read_ready;
    pp = (m_q.size() != 0) && bus.instr_ready;
    if (bus.stop) begin
      if (pp && m_fc != 16'hFFFF) m_fc++;
      m_run = 0; m_q.delete();
    end else if (bus.redirect) begin
      m_run = 1; m_pc = bus.redirect_pc; m_q.delete();
    end else if (!m_run) begin
      if (bus.start) begin m_run = 1; m_pc = bus.start_pc; m_fc = 0; end
    end else begin
      if (pp) begin void'(m_q.pop_front()); if (m_fc != 16'hFFFF) m_fc++; end
      if (hs) begin m_q.push_back(m_pc); m_pc++; end
    end
  endtask

  vec_t vt[22];
  int   npops;

  initial begin
    //        st spc    sp rd rpc    mr ir  mv ma     iv ipc
    vt[0]  = '{1, 8'h10, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00};
    vt[1]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h10, 0, 8'h00};
    vt[2]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 8'h10};
    vt[3]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h12, 1, 8'h11};
    vt[4]  = '{0, 8'h00, 1, 0, 8'h00, 1, 1, 1, 8'h13, 1, 8'h12};
    vt[5]  = '{1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h13, 0, 8'h00};
    vt[6]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 8'h00};
    vt[7]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h01, 1, 8'h00};
    vt[8]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h02, 1, 8'h00};
    vt[9]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h03, 1, 8'h00};
    vt[10] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h04, 1, 8'h00};
    vt[11] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h04, 1, 8'h01};
    vt[12] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 8'h05, 1, 8'h01};
    vt[13] = '{0, 8'h00, 0, 1, 8'h40, 1, 0, 1, 8'h05, 1, 8'h02};
    vt[14] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h40, 0, 8'h00};
    vt[15] = '{0, 8'h00, 1, 0, 8'h00, 1, 0, 1, 8'h41, 1, 8'h40};
    vt[16] = '{1, 8'hFE, 0, 0, 8'h00, 1, 1, 0, 8'h41, 0, 8'h00};
    vt[17] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'hFE, 0, 8'h00};
    vt[18] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'hFF, 1, 8'hFE};
    vt[19] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 8'hFF};
    vt[20] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h01, 1, 8'h00};
    vt[21] = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 8'h02, 1, 8'h01};

    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst mem_read_valid", bus.mem_read_valid, 0);
    check("rst mem_read_addr", bus.mem_read_addr, 0);
    check("rst instr_valid", bus.instr_valid, 0);
    check("rst instr", bus.instr, 0);
    check("rst instr_pc", bus.instr_pc, 0);
    check("rst fetch_count", bus.fetch_count, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed table: startup latency, fill to FULL, redirect mid-handshake, pc wrap.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vt[i].st, vt[i].spc, vt[i].sp, vt[i].rd, vt[i].rpc, vt[i].mr, vt[i].ir);
      #1;
      check($sformatf("v%0d mem_read_valid", i), bus.mem_read_valid, vt[i].e_mv);
      check($sformatf("v%0d mem_read_addr", i), bus.mem_read_addr, vt[i].e_ma);
      check($sformatf("v%0d instr_valid", i), bus.instr_valid, vt[i].e_iv);
      check($sformatf("v%0d instr_pc", i), bus.instr_pc, vt[i].e_ipc);
      check($sformatf("v%0d instr", i), bus.instr, vt[i].e_iv ? memf(vt[i].e_ipc) : 8'h00);
    end

    // Delivered-instruction counter: 10 pops, then cleared by a fresh start.
    @(negedge clk); drive(0, 0, 1, 0, 0, 1, 0);
    @(negedge clk); drive(1, 8'h20, 0, 0, 0, 1, 1);
    npops = 0;
    for (int c = 0; c < 40 && npops < 10; c++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1);
      #1 if (bus.instr_valid) npops++;
    end
    check("pop budget", npops, 10);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 0);
    #1 check("fetch_count after 10", bus.fetch_count, STATS ? 16'd10 : 16'd0);
    @(negedge clk); drive(0, 0, 1, 0, 0, 1, 0);
    @(negedge clk); drive(1, 8'h00, 0, 0, 0, 0, 0);
    #1 check("fetch_count held", bus.fetch_count, STATS ? 16'd10 : 16'd0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
    #1 check("fetch_count start clr", bus.fetch_count, 0);

    // Stalled request holds its address; async reset drops it mid-stall.
    @(negedge clk); drive(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk); drive(1, 8'h33, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check($sformatf("stall%0d mem_read_valid", c), bus.mem_read_valid, 1);
      check($sformatf("stall%0d mem_read_addr", c), bus.mem_read_addr, 8'h33);
      check($sformatf("stall%0d instr_valid", c), bus.instr_valid, 0);
    end
    reset = 1'b1;
    #1;
    check("async mem_read_valid", bus.mem_read_valid, 0);
    check("async mem_read_addr", bus.mem_read_addr, 0);
    check("async instr_valid", bus.instr_valid, 0);
    check("async instr", bus.instr, 0);
    check("async instr_pc", bus.instr_pc, 0);
    check("async fetch_count", bus.fetch_count, 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0; drive(0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post-rst mem_read_valid", bus.mem_read_valid, 0);
      check("post-rst instr_valid", bus.instr_valid, 0);
    end

    // Random traffic against the model, which starts from the reset state.
    m_run = 0; m_pc = 8'h00; m_q.delete(); m_fc = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 49) == 0,
            $urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < ((c < 1500) ? 30 : 75));
      #1;
      m_check();
      m_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning program-memory address width.
REQ-003 The block SHALL have parameter INSTR_W, default 8, meaning instruction width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin fetching at start_pc; honoured only in IDLE.
REQ-007 The block SHALL have port start_pc, input, ADDR_W bits: first fetch address.
REQ-008 The block SHALL have port stop, input, 1 bit: abandon fetching, flush the queue and return to IDLE.
REQ-009 The block SHALL have port redirect, input, 1 bit: flush the queue and resume fetching at redirect_pc.
REQ-010 The block SHALL have port redirect_pc, input, ADDR_W bits: redirect target.
REQ-011 The block SHALL have port mem_read_valid, output, 1 bit: fetch request.
REQ-012 The block SHALL have port mem_read_addr, output, ADDR_W bits: fetch address.
REQ-013 The block SHALL have port mem_read_ready, input, 1 bit: request accepted; mem_read_data is valid in the same cycle.
REQ-014 The block SHALL have port mem_read_data, input, INSTR_W bits: fetched instruction.
REQ-015 The block SHALL have port instr_valid, output, 1 bit: head entry available to the decoder.
REQ-016 The block SHALL have port instr, output, INSTR_W bits: head instruction.
REQ-017 The block SHALL have port instr_pc, output, ADDR_W bits: address of the head instruction.
REQ-018 The block SHALL have port instr_ready, input, 1 bit: decoder consumes the head entry.
REQ-019 The block SHALL have port fetch_count, output, 16 bits: count of delivered instructions (see Configuration).

Function
REQ-020 The state machine SHALL have states IDLE, FETCH and FULL.
REQ-021 Transitions SHALL be: IDLE->FETCH on start, with pc<=start_pc; FETCH->FULL when count==DEPTH; FULL->FETCH when count<DEPTH; any state->IDLE on stop.
REQ-022 mem_read_valid SHALL equal (state==FETCH && count<DEPTH), and mem_read_addr SHALL equal pc.
REQ-023 A request SHALL hold its address stable until mem_read_valid&&mem_read_ready.
REQ-024 On a handshake, {mem_read_data, pc} SHALL be pushed and pc SHALL increment modulo 2^ADDR_W (0xFF wraps to 0x00, fetching continues).
REQ-025 instr_valid SHALL equal (count!=0), and instr/instr_pc SHALL present the head entry combinationally.
REQ-026 A pop SHALL occur on instr_valid&&instr_ready.
REQ-027 The push decision SHALL use count before the pop, so a full queue does not accept a push even when popping.
REQ-028 Simultaneous push and pop SHALL leave count unchanged.
REQ-029 Latency SHALL be: start in cycle N, request in N+1; if ready in N+1, instr_valid in N+2.
REQ-030 redirect SHALL clear the queue (count<=0), discard any same-cycle handshake data, set pc<=redirect_pc and set state<=FETCH.
REQ-031 No pop SHALL be counted in a redirect cycle.
REQ-032 Priority SHALL be stop > redirect > start > normal operation.
REQ-033 instr_ready asserted while the queue is empty SHALL be ignored.

Reset
REQ-034 Reset SHALL be asynchronous: state=IDLE, pc=0, count=0, read and write pointers=0, mem_read_valid=0, mem_read_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0.
REQ-035 Reset asserted mid-request SHALL drop the request immediately, with no further handshakes until the next start.
REQ-036 Queue storage SHALL need no reset, but instr SHALL read 0 while the queue is empty.

Configuration
REQ-037 With macro PREFETCH_STATS_EN defined, fetch_count SHALL increment on every pop, saturate at 0xFFFF and clear on reset or start.
REQ-038 Without PREFETCH_STATS_EN, fetch_count SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-039 Package gpu_pkg SHALL hold ADDR_W and INSTR_W defaults and the fetch-state enum (IDLE/FETCH/FULL).
REQ-040 Storage SHALL be one sub-module, pq_fifo (DEPTH x (INSTR_W+ADDR_W), push/pop/flush, count output); the FSM, pc and request logic SHALL reside in prefetch_queue.

Verification
REQ-041 Scenario: start=1 with start_pc=0x10, mem_read_ready always 1, instr_ready=1 -> request addr 0x10 in cycle 1; instr=mem[0x10] with instr_pc=0x10 in cycle 2; then one instruction per cycle.
REQ-042 Scenario: instr_ready=0, DEPTH=4, fetch from 0x00 -> four handshakes (0x00..0x03), state FULL, mem_read_valid=0; then instr_ready=1 for one cycle -> pop 0x00 and request 0x04 on the following cycle.
REQ-043 Scenario: start_pc=0xFE with ready=1 -> delivered pcs 0xFE, 0xFF, 0x00, 0x01.
REQ-044 Scenario: queue holding 3 entries, redirect with redirect_pc=0x40 in the same cycle as a handshake -> count=0 next cycle, handshake data discarded, next request addr 0x40.
REQ-045 Scenario: mem_read_ready=0 for 5 cycles -> mem_read_addr held constant and instr_valid=0; reset asserted in cycle 3 -> all outputs 0 in that cycle without waiting for a clock edge.
REQ-046 Scenario: with PREFETCH_STATS_EN, 10 pops -> fetch_count=10, and a subsequent start -> fetch_count=0; without the macro -> fetch_count=0 throughout.
